mole_sched: RTL
===============

# mole_sched

Whack-a-mole round scheduler: consumes the free-running 5-bit random value (range 1..30), turns it into a one-hot mole position, times how long each mole stays up, checks player button hits, and keeps score and miss count until the game ends. Sits between the random generator and the LED, score and display logic. It is the consumer end of the random-value interface.

## Interface
- `N_HOLES`, default 8: number of holes. Power of two, range 2..16.
- `GAP_CYCLES`, default 50_000_000: idle time between moles, in cycles. Must be ≥1.
- `UP_CYCLES`, default 75_000_000: time a mole stays up, in cycles. Must be ≥1.
- `HIT_CYCLES`, default 25_000_000: cooldown after a hit, in cycles. Must be ≥1.
- `MAX_MISSES`, default 5: number of timeouts that ends the game. Range 1..15.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level or pulse. Honoured only in IDLE or DONE.
- `rand` in 5: random value. Valid values are 1..30; sampled only at the end of GAP.
- `btn` in N_HOLES: debounced one-cycle hit pulses, one bit per hole.
- `mole` out N_HOLES: one-hot active mole, registered.
- `score` out 8: hit count, saturates at 255.
- `misses` out 4: timeout count.
- `busy` out 1: high in GAP, UP and HIT.
- `game_over` out 1: high in DONE.

## Operation
- States: IDLE, GAP, UP, HIT, DONE. One down-counter, shared by all states. Its width is clog2 of max(GAP,UP,HIT)+1.
- **IDLE**, with `start`=1: go to GAP. Load counter = GAP_CYCLES−1. Clear score and misses.
- **GAP**: decrement the counter. At counter==0:
  - Compute `cand = (rand−1) mod N_HOLES`, i.e. the low bits of `rand−1`.
  - If `cand == prev_hole`, use `cand+1 mod N_HOLES` instead. No mole repeats in the same hole twice in a row.
  - Latch the result into `prev_hole`. Set `mole` to the one-hot of the hole. Load counter = UP_CYCLES−1. Go to UP.
  - `rand` = 0 or 31 is out of range. Treat it as `rand` = 1.
- **UP**:
  - `btn[hole]`=1: score+1 (saturating), `mole`←0, counter←HIT_CYCLES−1, go to HIT.
  - Else if counter==0: misses+1, `mole`←0. If the new misses == MAX_MISSES, go to DONE. Else counter←GAP_CYCLES−1, go to GAP.
  - Pulses on other `btn` bits are ignored. No penalty.
  - A hit and the timeout in the same cycle: the hit wins, and misses is unchanged.
- **HIT**: decrement the counter. At 0: counter←GAP_CYCLES−1, go to GAP. All `btn` is ignored.
- **DONE**: hold score and misses. `start`=1 behaves exactly as in IDLE: clear score and misses, go to GAP.
- `start` in GAP, UP or HIT is ignored.
- `prev_hole` resets to 0 and is not cleared by `start`.

## Timing
- Reset values:
  - state = IDLE
  - `mole` = 0, `score` = 0, `misses` = 0
  - `busy` = 0, `game_over` = 0
  - counter = 0, `prev_hole` = 0
- Reset takes priority over all other inputs in every state. Reset mid-round drops the mole on the next edge.
- The `start` edge puts the FSM in GAP. The first mole appears exactly GAP_CYCLES cycles after the FSM enters GAP.
- `mole` stays high for exactly UP_CYCLES cycles if no hit occurs.
- A `btn` pulse on the lit hole at edge k:
  - `mole`=0 and `score` incremented, both visible after edge k.
  - The next GAP begins after HIT_CYCLES further cycles.
- `rand` is sampled once per mole, in the final GAP cycle only. Changes at any other time have no effect.
- All outputs are registered, with no combinational path from input to output. `busy` and `game_over` are decoded from the registered state.

## Structure
- Shared package `mole_pkg`:
  - state enum (IDLE, GAP, UP, HIT, DONE)
  - `RAND_W` = 5, `SCORE_W` = 8, `MISS_W` = 4
  - `RAND_MIN` = 1, `RAND_MAX` = 30
- One natural sub-module: `hole_pick`. It is combinational and takes rand and prev_hole, and returns the hole index. This includes the out-of-range clamp and the repeat-avoid step. It is reused later by a multi-mole variant.
- Everything else (FSM, counter, score and miss registers) lives in `mole_sched`.

## Test plan
All scenarios use N_HOLES=8, GAP=4, UP=6, HIT=3, MAX_MISSES=2.
- **Start and timeout:** reset, then pulse `start`, with `rand` held at 5 → after 4 cycles, `mole`=8'b0001_0000 (hole 4) for 6 cycles. Then `misses`=1, and `mole`=0 for 4 cycles.
- **Repeat-avoid and game over:** continue the first scenario with `rand` still 5 → the second mole is at hole 5 (8'b0010_0000). On its timeout, `misses`=2, `game_over`=1, `busy`=0. Further `start`-free cycles hold all outputs.
- **Hit:** `rand`=1 gives hole 0 → pulse `btn[0]` on the 3rd UP cycle. `score`=1 and `mole`=0 on the next edge. HIT lasts 3 cycles, then GAP lasts 4 cycles.
- **Wrong button and hit/timeout collision:** a `btn[3]` pulse while hole 0 is lit has no effect. `btn[0]` in the last UP cycle → `score`+1, `misses` unchanged.
- **Out-of-range rand and score saturation:** `rand`=0 and `rand`=31 both select hole 0 (or hole 1 if the previous hole was 0). Force 256 hits → `score` stays at 255.
- **Reset mid-round:** assert `rst` in UP → `mole`=0, `score`=0, state IDLE on the next edge. A later `start` runs normally.

Source files
------------

// File: rtl/mole_sched_pkg.sv
// Shared types and constants for the whack-a-mole scheduler.
//   state_e     : round FSM states
//   RAND_W      : width of the random value from the generator
//   SCORE_W     : width of the hit counter
//   MISS_W      : width of the timeout counter
//   RAND_MIN/MAX: legal range of the random value
//   max3()      : elaboration-time helper used to size the shared counter
package mole_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StUp,
    StHit,
    StDone
  } state_e;

  localparam int unsigned RAND_W  = 5;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned MISS_W  = 4;

  localparam logic [RAND_W-1:0] RAND_MIN = 5'd1;
  localparam logic [RAND_W-1:0] RAND_MAX = 5'd30;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/mole_sched_if.sv
// Player/round interface of the mole scheduler.
//   start_i     : begin a game (honoured in idle/done only)
//   rand_i      : random value from the generator, 1..30 nominal
//   btn_i       : one-cycle debounced hit pulses, one per hole
//   mole_o      : one-hot lit hole
//   score_o     : hit count, saturating
//   misses_o    : timeout count
//   busy_o      : a round is in progress
//   game_over_o : game has ended
// master = driver side (generator, buttons, display), slave = scheduler.
interface mole_sched_if #(
  parameter int unsigned N_HOLES = 8
);

  logic                        start_i;
  logic [mole_pkg::RAND_W-1:0] rand_i;
  logic [N_HOLES-1:0]          btn_i;
  logic [N_HOLES-1:0]          mole_o;
  logic [mole_pkg::SCORE_W-1:0] score_o;
  logic [mole_pkg::MISS_W-1:0] misses_o;
  logic                        busy_o;
  logic                        game_over_o;

  modport master (
    output start_i,
    output rand_i,
    output btn_i,
    input  mole_o,
    input  score_o,
    input  misses_o,
    input  busy_o,
    input  game_over_o
  );

  modport slave (
    input  start_i,
    input  rand_i,
    input  btn_i,
    output mole_o,
    output score_o,
    output misses_o,
    output busy_o,
    output game_over_o
  );

endinterface

// File: rtl/mole_sched_hole_pick.sv
// Combinational hole selector.
//   rand_i      : raw random value; 0 and 31 are clamped to 1
//   prev_hole_i : hole used by the previous mole
//   hole_o      : chosen hole index, never equal to prev_hole_i
module hole_pick
  import mole_pkg::*;
#(
  parameter int unsigned N_HOLES = 8
) (
  input  logic [RAND_W-1:0]          rand_i,
  input  logic [$clog2(N_HOLES)-1:0] prev_hole_i,
  output logic [$clog2(N_HOLES)-1:0] hole_o
);

  localparam int unsigned HoleW = $clog2(N_HOLES);

  logic [RAND_W-1:0] rand_c;
  logic [RAND_W-1:0] rand_m1;
  logic [HoleW-1:0]  cand;

  always_comb begin
    rand_c = rand_i;
    if (rand_i < RAND_MIN || rand_i > RAND_MAX) begin
      rand_c = RAND_MIN;
    end
    rand_m1 = rand_c - RAND_MIN;
    // N_HOLES is a power of two, so mod is just the low bits.
    cand    = rand_m1[HoleW-1:0];
    hole_o  = cand;
    if (cand == prev_hole_i) begin
      hole_o = cand + 1'b1;
    end
  end

endmodule

// File: rtl/mole_sched.sv
// Whack-a-mole round scheduler.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : mole_sched_if slave (start, rand, btn in; mole, score, misses, busy, game_over out)
// One down-counter is shared by the gap, up and hit phases. The lit hole is
// held one-hot in mole_q, so a hit is simply any btn bit overlapping it.
module mole_sched
  import mole_pkg::*;
#(
  parameter int unsigned N_HOLES    = 8,
  parameter int unsigned GAP_CYCLES = 50_000_000,
  parameter int unsigned UP_CYCLES  = 75_000_000,
  parameter int unsigned HIT_CYCLES = 25_000_000,
  parameter int unsigned MAX_MISSES = 5
) (
  input  logic          clk,
  input  logic          rst,
  mole_sched_if.slave   bus
);

  localparam int unsigned HoleW = $clog2(N_HOLES);
  localparam int unsigned CntW  = $clog2(max3(GAP_CYCLES, UP_CYCLES, HIT_CYCLES) + 1);

  localparam logic [CntW-1:0]   GapLoad = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0]   UpLoad  = CntW'(UP_CYCLES - 1);
  localparam logic [CntW-1:0]   HitLoad = CntW'(HIT_CYCLES - 1);
  localparam logic [MISS_W-1:0] MaxMiss = MISS_W'(MAX_MISSES);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [HoleW-1:0]     prev_q, prev_d;
  logic [N_HOLES-1:0]   mole_q, mole_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [MISS_W-1:0]    misses_q, misses_d;

  logic [HoleW-1:0]     pick;
  logic [MISS_W-1:0]    misses_inc;
  logic                 hit;

  hole_pick #(
    .N_HOLES (N_HOLES)
  ) u_hole_pick (
    .rand_i      (bus.rand_i),
    .prev_hole_i (prev_q),
    .hole_o      (pick)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    mole_d     = mole_q;
    score_d    = score_q;
    misses_d   = misses_q;
    hit        = |(bus.btn_i & mole_q);
    misses_inc = misses_q + 1'b1;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start_i) begin
          state_d  = StGap;
          cnt_d    = GapLoad;
          score_d  = '0;
          misses_d = '0;
        end
      end

      StGap: begin
        if (cnt_q == '0) begin
          // rand is only looked at here, in the final gap cycle.
          prev_d  = pick;
          mole_d  = N_HOLES'(1) << pick;
          cnt_d   = UpLoad;
          state_d = StUp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StUp: begin
        // Hit is checked first so it wins over a same-cycle timeout.
        if (hit) begin
          if (score_q != '1) score_d = score_q + 1'b1;
          mole_d  = '0;
          cnt_d   = HitLoad;
          state_d = StHit;
        end else if (cnt_q == '0) begin
          misses_d = misses_inc;
          mole_d   = '0;
          if (misses_inc == MaxMiss) begin
            state_d = StDone;
          end else begin
            cnt_d   = GapLoad;
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StHit: begin
        if (cnt_q == '0) begin
          cnt_d   = GapLoad;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prev_q   <= '0;
      mole_q   <= '0;
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      mole_q   <= mole_d;
      score_q  <= score_d;
      misses_q <= misses_d;
    end
  end

  assign bus.mole_o      = mole_q;
  assign bus.score_o     = score_q;
  assign bus.misses_o    = misses_q;
  assign bus.busy_o      = (state_q == StGap) || (state_q == StUp) || (state_q == StHit);
  assign bus.game_over_o = (state_q == StDone);

endmodule
